tcp_echo_engine: RTL and testbench

Store-and-forward echo core sitting between the TCP offload stack's receive interface and its transmit interface inside `tcp_echo_app_design`. It accepts one received segment at a time (session metadata plus AXI-Stream payload) and buffers it in an on-chip FIFO. It then issues a transmit request (session and byte length) and replays the payload unchanged to the same session. Oversized and empty segments are discarded and never transmitted.

---
 rtl/tcp_echo_pkg.sv | 22 ++
 rtl/echo_pkt_fifo.sv | 51 +++++
 rtl/tcp_echo_engine.sv | 215 +++++++++++++++++++++
 tb/tb_tcp_echo_engine.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_echo_pkg.sv
// Shared types for the TCP echo engine: FSM states,
// field widths and the packed tx request record.
package tcp_echo_pkg;

  localparam int SESSION_W = 16;
  localparam int LEN_W     = 16;
  localparam int STATUS_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_DATA,
    ST_TX_META,
    ST_TX_DATA,
    ST_FLUSH
  } echo_state_t;

  typedef struct packed {
    logic [LEN_W-1:0]     len;
    logic [SESSION_W-1:0] session;
  } tx_meta_t;

endpackage

// File: rtl/echo_pkt_fifo.sv
// First-word fall-through packet FIFO.
// Ports: wr_en/wr_data push, rd_en pops, rd_data = head;
// full, empty, one (exactly one entry); async active-low rst_n.
module echo_pkt_fifo #(
  parameter int W     = 73,
  parameter int DEPTH = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         one
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  level;
  logic         push;
  logic         pop;

  assign level = wr_ptr - rd_ptr;
  assign full  = level[AW];
  assign empty = (level == '0);
  assign one   = (level == (AW+1)'(1));
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/tcp_echo_engine.sv
// Store-and-forward TCP echo: buffers one rx segment, then
// requests tx {len,session} and replays the payload unchanged.
// Ports: s_rx_meta/s_rx_data in, m_tx_meta/m_tx_data out,
// s_tx_status strobe, busy. `TCP_ECHO_STATS_EN adds stat_* counters.
module tcp_echo_engine
  import tcp_echo_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic                 s_rx_meta_tvalid,
  output logic                 s_rx_meta_tready,
  input  logic [SESSION_W-1:0] s_rx_meta_tdata,
  input  logic                 s_rx_data_tvalid,
  output logic                 s_rx_data_tready,
  input  logic [DATA_W-1:0]    s_rx_data_tdata,
  input  logic [DATA_W/8-1:0]  s_rx_data_tkeep,
  input  logic                 s_rx_data_tlast,
  output logic                 m_tx_meta_tvalid,
  input  logic                 m_tx_meta_tready,
  output logic [31:0]          m_tx_meta_tdata,
  output logic                 m_tx_data_tvalid,
  input  logic                 m_tx_data_tready,
  output logic [DATA_W-1:0]    m_tx_data_tdata,
  output logic [DATA_W/8-1:0]  m_tx_data_tkeep,
  output logic                 m_tx_data_tlast,
  input  logic                 s_tx_status_tvalid,
  input  logic [STATUS_W-1:0]  s_tx_status_tdata,
  output logic                 busy
`ifdef TCP_ECHO_STATS_EN
  ,
  output logic [31:0]          stat_echoed,
  output logic [31:0]          stat_dropped,
  output logic [31:0]          stat_tx_err
`endif
);

  localparam int KW = DATA_W / 8;
  localparam int FW = DATA_W + KW + 1;

  if (FIFO_DEPTH * KW > 65535) begin : g_len_chk
    $error("segment byte count would overflow LEN_W");
  end

  echo_state_t          state;
  logic [SESSION_W-1:0] session;
  logic [LEN_W-1:0]     byte_cnt;
  logic                 ovf;
  tx_meta_t             meta_q;

  logic [LEN_W-1:0] keep_cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             rx_fire;
  logic             rx_last_fire;
  logic             drop_seg;
  logic             tx_fire;
  logic             tx_last_fire;

  logic          fifo_wr;
  logic          fifo_rd;
  logic [FW-1:0] fifo_wdata;
  logic [FW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_one;

  logic              head_last;
  logic [KW-1:0]     head_keep;
  logic [DATA_W-1:0] head_data;
  logic              tx_valid;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KW; i++) begin
      keep_cnt = keep_cnt + LEN_W'(s_rx_data_tkeep[i]);
    end
  end

  assign rx_fire      = s_rx_data_tvalid & s_rx_data_tready;
  assign rx_last_fire = rx_fire & s_rx_data_tlast;
  assign cnt_nxt      = byte_cnt + keep_cnt;
  assign ovf_nxt      = ovf | fifo_full;
  assign drop_seg     = ovf_nxt | (cnt_nxt == '0);

  assign fifo_wr    = rx_fire & ~fifo_full;
  assign fifo_wdata = {s_rx_data_tlast, s_rx_data_tkeep,
                       s_rx_data_tdata};

  assign {head_last, head_keep, head_data} = fifo_rdata;

  assign tx_valid     = (state == ST_TX_DATA) & ~fifo_empty;
  assign tx_fire      = tx_valid & m_tx_data_tready;
  assign tx_last_fire = tx_fire & head_last;
  assign fifo_rd      = tx_fire |
                        ((state == ST_FLUSH) & ~fifo_empty);

  // Payload outputs read zero whenever no beat is offered.
  assign m_tx_data_tvalid = tx_valid;
  assign m_tx_data_tdata  = tx_valid ? head_data : '0;
  assign m_tx_data_tkeep  = tx_valid ? head_keep : '0;
  assign m_tx_data_tlast  = tx_valid & head_last;
  assign m_tx_meta_tdata  = meta_q;

  echo_pkt_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .one     (fifo_one)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= ST_IDLE;
      session          <= '0;
      byte_cnt         <= '0;
      ovf              <= 1'b0;
      meta_q           <= '0;
      s_rx_meta_tready <= 1'b1;
      s_rx_data_tready <= 1'b0;
      m_tx_meta_tvalid <= 1'b0;
      busy             <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (s_rx_meta_tvalid) begin
            session          <= s_rx_meta_tdata;
            byte_cnt         <= '0;
            ovf              <= 1'b0;
            state            <= ST_RX_DATA;
            s_rx_meta_tready <= 1'b0;
            s_rx_data_tready <= 1'b1;
            busy             <= 1'b1;
          end
        end
        ST_RX_DATA: begin
          if (rx_fire) begin
            byte_cnt <= cnt_nxt;
            ovf      <= ovf_nxt;
          end
          if (rx_last_fire) begin
            s_rx_data_tready <= 1'b0;
            if (drop_seg) begin
              state <= ST_FLUSH;
            end else begin
              state            <= ST_TX_META;
              m_tx_meta_tvalid <= 1'b1;
              meta_q           <= '{len: cnt_nxt,
                                    session: session};
            end
          end
        end
        ST_TX_META: begin
          if (m_tx_meta_tready) begin
            m_tx_meta_tvalid <= 1'b0;
            state            <= ST_TX_DATA;
          end
        end
        ST_TX_DATA: begin
          if (tx_last_fire) begin
            state            <= ST_IDLE;
            s_rx_meta_tready <= 1'b1;
            busy             <= 1'b0;
          end
        end
        ST_FLUSH: begin
          // The last remaining beat pops this cycle.
          if (fifo_empty || fifo_one) begin
            state            <= ST_IDLE;
            s_rx_meta_tready <= 1'b1;
            busy             <= 1'b0;
          end
        end
        default: begin
          state            <= ST_IDLE;
          s_rx_meta_tready <= 1'b1;
          s_rx_data_tready <= 1'b0;
          m_tx_meta_tvalid <= 1'b0;
          busy             <= 1'b0;
        end
      endcase
    end
  end

`ifdef TCP_ECHO_STATS_EN
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_echoed  <= '0;
      stat_dropped <= '0;
      stat_tx_err  <= '0;
    end else begin
      if (tx_last_fire) stat_echoed <= stat_echoed + 1'b1;
      if (state == ST_RX_DATA && rx_last_fire && drop_seg)
        stat_dropped <= stat_dropped + 1'b1;
      if (s_tx_status_tvalid && |s_tx_status_tdata)
        stat_tx_err <= stat_tx_err + 1'b1;
    end
  end
`else
  logic unused_status;
  assign unused_status = ^{s_tx_status_tvalid,
                           s_tx_status_tdata};
`endif

endmodule

// File: tb/tb_tcp_echo_engine.sv
// Directed bench for tcp_echo_engine: table of segments plus
// hand sequences for mid-segment reset and status strobes.
module tb_tcp_echo_engine;

  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          sys_rst_n;
  logic          s_rx_meta_tvalid;
  logic          s_rx_meta_tready;
  logic [15:0]   s_rx_meta_tdata;
  logic          s_rx_data_tvalid;
  logic          s_rx_data_tready;
  logic [DW-1:0] s_rx_data_tdata;
  logic [KW-1:0] s_rx_data_tkeep;
  logic          s_rx_data_tlast;
  logic          m_tx_meta_tvalid;
  logic          m_tx_meta_tready;
  logic [31:0]   m_tx_meta_tdata;
  logic          m_tx_data_tvalid;
  logic          m_tx_data_tready;
  logic [DW-1:0] m_tx_data_tdata;
  logic [KW-1:0] m_tx_data_tkeep;
  logic          m_tx_data_tlast;
  logic          s_tx_status_tvalid;
  logic [1:0]    s_tx_status_tdata;
  logic          busy;
`ifdef TCP_ECHO_STATS_EN
  logic [31:0]   stat_echoed;
  logic [31:0]   stat_dropped;
  logic [31:0]   stat_tx_err;
`endif

  always #5 clk = ~clk;

  tcp_echo_engine #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .sys_rst_n          (sys_rst_n),
    .s_rx_meta_tvalid   (s_rx_meta_tvalid),
    .s_rx_meta_tready   (s_rx_meta_tready),
    .s_rx_meta_tdata    (s_rx_meta_tdata),
    .s_rx_data_tvalid   (s_rx_data_tvalid),
    .s_rx_data_tready   (s_rx_data_tready),
    .s_rx_data_tdata    (s_rx_data_tdata),
    .s_rx_data_tkeep    (s_rx_data_tkeep),
    .s_rx_data_tlast    (s_rx_data_tlast),
    .m_tx_meta_tvalid   (m_tx_meta_tvalid),
    .m_tx_meta_tready   (m_tx_meta_tready),
    .m_tx_meta_tdata    (m_tx_meta_tdata),
    .m_tx_data_tvalid   (m_tx_data_tvalid),
    .m_tx_data_tready   (m_tx_data_tready),
    .m_tx_data_tdata    (m_tx_data_tdata),
    .m_tx_data_tkeep    (m_tx_data_tkeep),
    .m_tx_data_tlast    (m_tx_data_tlast),
    .s_tx_status_tvalid (s_tx_status_tvalid),
    .s_tx_status_tdata  (s_tx_status_tdata),
    .busy               (busy)
`ifdef TCP_ECHO_STATS_EN
    ,
    .stat_echoed        (stat_echoed),
    .stat_dropped       (stat_dropped),
    .stat_tx_err        (stat_tx_err)
`endif
  );

  typedef struct {
    logic [15:0] sess;
    int          nbeats;
    logic [7:0]  last_keep;
    bit          tog;
    bit          echo;
    logic [31:0] exp_meta;
    int          idle_bound;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   exp_echo = 0;
  int   exp_drop = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_word(input logic [15:0] s,
                                            input int i);
    return {s, 16'(i), 32'hC0DE_0000 | 32'(i * 7)};
  endfunction

  task automatic send_meta(input logic [15:0] s);
    bit ok = 0;
    s_rx_meta_tvalid = 1'b1;
    s_rx_meta_tdata  = s;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (s_rx_meta_tready) ok = 1;
      @(posedge clk); #1;
    end
    s_rx_meta_tvalid = 1'b0;
    if (!ok) check("rx_meta_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_beat(input logic [15:0] s, input int i,
                           input logic [7:0] keep,
                           input bit last);
    bit ok = 0;
    s_rx_data_tvalid = 1'b1;
    s_rx_data_tdata  = beat_word(s, i);
    s_rx_data_tkeep  = keep;
    s_rx_data_tlast  = last;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (s_rx_data_tready) ok = 1;
      @(posedge clk); #1;
    end
    s_rx_data_tvalid = 1'b0;
    s_rx_data_tlast  = 1'b0;
    if (!ok) check("rx_data_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_echo(input vec_t v);
    int  k = 0;
    bit  done = 0;
    logic [7:0] ek;
    m_tx_meta_tready = 1'b0;
    check("tx_meta_tdata", 64'(m_tx_meta_tdata), 64'(v.exp_meta));
    if (v.tog) begin
      @(posedge clk); #1;
      check("tx_meta_hold_valid", 64'(m_tx_meta_tvalid), 64'd1);
      check("tx_meta_hold_tdata", 64'(m_tx_meta_tdata),
            64'(v.exp_meta));
      check("tx_data_idle_in_meta", 64'(m_tx_data_tvalid), 64'd0);
    end
    m_tx_meta_tready = 1'b1;
    @(posedge clk); #1;
    m_tx_meta_tready = 1'b0;
    check("tx_meta_drop_after_hs", 64'(m_tx_meta_tvalid), 64'd0);
    check("tx_data_valid_latency", 64'(m_tx_data_tvalid), 64'd1);
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      m_tx_data_tready = v.tog ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (m_tx_data_tvalid && m_tx_data_tready) begin
        ek = (k == v.nbeats - 1) ? v.last_keep : 8'hFF;
        if (k < v.nbeats) begin
          check("tx_tdata", m_tx_data_tdata, beat_word(v.sess, k));
          check("tx_tkeep", 64'(m_tx_data_tkeep), 64'(ek));
          check("tx_tlast", 64'(m_tx_data_tlast),
                64'(k == v.nbeats - 1));
        end else begin
          check("tx_extra_beat", 64'(k), 64'(v.nbeats - 1));
        end
        if (m_tx_data_tlast) done = 1;
        k++;
      end
      @(posedge clk); #1;
    end
    m_tx_data_tready = 1'b0;
    check("tx_done", 64'(done), 64'd1);
    check("tx_beat_count", 64'(k), 64'(v.nbeats));
    check("busy_after_echo", 64'(busy), 64'd0);
  endtask

  task automatic expect_drop(input vec_t v);
    bit tx_seen = 0;
    check("no_tx_meta_on_drop", 64'(m_tx_meta_tvalid), 64'd0);
    for (int c = 0; c < v.idle_bound && busy; c++) begin
      @(negedge clk);
      if (m_tx_meta_tvalid || m_tx_data_tvalid) tx_seen = 1;
      @(posedge clk); #1;
    end
    check("drop_back_idle", 64'(busy), 64'd0);
    check("drop_rx_meta_tready", 64'(s_rx_meta_tready), 64'd1);
    check("drop_no_tx", 64'(tx_seen), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    send_meta(v.sess);
    check("rx_data_tready_latency", 64'(s_rx_data_tready), 64'd1);
    check("busy_in_rx", 64'(busy), 64'd1);
    for (int i = 0; i < v.nbeats; i++) begin
      send_beat(v.sess, i,
                (i == v.nbeats - 1) ? v.last_keep : 8'hFF,
                i == v.nbeats - 1);
    end
    if (v.echo) begin
      check("tx_meta_valid_latency", 64'(m_tx_meta_tvalid), 64'd1);
      expect_echo(v);
      exp_echo++;
    end else begin
      expect_drop(v);
      exp_drop++;
    end
  endtask

  initial begin
    vec_t fresh;
    vecs[0] = '{16'h0012, 3, 8'h0F, 1'b0, 1'b1, 32'h0014_0012, 0};
    vecs[1] = '{16'h0012, 3, 8'h0F, 1'b1, 1'b1, 32'h0014_0012, 0};
    vecs[2] = '{16'h00A1, 17, 8'hFF, 1'b0, 1'b0, 32'h0, 40};
    vecs[3] = '{16'h0034, 1, 8'h01, 1'b0, 1'b1, 32'h0001_0034, 0};
    vecs[4] = '{16'h00B2, 1, 8'h00, 1'b0, 1'b0, 32'h0, 2};
    vecs[5] = '{16'hBEEF, 5, 8'h7F, 1'b1, 1'b1, 32'h0027_BEEF, 0};
    fresh   = '{16'h0055, 2, 8'hFF, 1'b0, 1'b1, 32'h0010_0055, 0};

    sys_rst_n          = 1'b0;
    s_rx_meta_tvalid   = 1'b0;
    s_rx_meta_tdata    = '0;
    s_rx_data_tvalid   = 1'b0;
    s_rx_data_tdata    = '0;
    s_rx_data_tkeep    = '0;
    s_rx_data_tlast    = 1'b0;
    m_tx_meta_tready   = 1'b0;
    m_tx_data_tready   = 1'b0;
    s_tx_status_tvalid = 1'b0;
    s_tx_status_tdata  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_meta_tready", 64'(s_rx_meta_tready), 64'd1);
    check("rst_rx_data_tready", 64'(s_rx_data_tready), 64'd0);
    check("rst_tx_meta_tvalid", 64'(m_tx_meta_tvalid), 64'd0);
    check("rst_tx_meta_tdata", 64'(m_tx_meta_tdata), 64'd0);
    check("rst_tx_data_tvalid", 64'(m_tx_data_tvalid), 64'd0);
    check("rst_tx_data_tdata", m_tx_data_tdata, 64'd0);
    check("rst_tx_data_tkeep", 64'(m_tx_data_tkeep), 64'd0);
    check("rst_tx_data_tlast", 64'(m_tx_data_tlast), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
`ifdef TCP_ECHO_STATS_EN
    check("rst_stat_echoed", 64'(stat_echoed), 64'd0);
    check("rst_stat_dropped", 64'(stat_dropped), 64'd0);
    check("rst_stat_tx_err", 64'(stat_tx_err), 64'd0);
`endif
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(posedge clk); #1;

    // Abandon a segment mid-payload with an async reset.
    send_meta(16'h0077);
    send_beat(16'h0077, 0, 8'hFF, 1'b0);
    send_beat(16'h0077, 1, 8'hFF, 1'b0);
    @(negedge clk);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rx_meta_tready", 64'(s_rx_meta_tready), 64'd1);
    check("midrst_rx_data_tready", 64'(s_rx_data_tready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(fresh);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Status strobes never disturb the FSM.
    s_tx_status_tvalid = 1'b1;
    s_tx_status_tdata  = 2'd1;
    @(posedge clk); #1;
    s_tx_status_tdata  = 2'd0;
    @(posedge clk); #1;
    s_tx_status_tdata  = 2'd2;
    @(posedge clk); #1;
    s_tx_status_tvalid = 1'b0;
    s_tx_status_tdata  = 2'd3;
    @(posedge clk); #1;
    check("status_busy", 64'(busy), 64'd0);
    check("status_rx_meta_tready", 64'(s_rx_meta_tready), 64'd1);
    check("status_tx_meta_tvalid", 64'(m_tx_meta_tvalid), 64'd0);
`ifdef TCP_ECHO_STATS_EN
    check("stat_echoed", 64'(stat_echoed), 64'(exp_echo));
    check("stat_dropped", 64'(stat_dropped), 64'(exp_drop));
    check("stat_tx_err", 64'(stat_tx_err), 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
